// File: rtl/key_event_decoder_if.sv
// rtl/key_event_decoder_if.sv - key event valid/ready handshake bundle
interface key_event_decoder_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;
    logic       evt_ovf;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_ovf,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_ovf,
        output evt_ready
    );
endinterface

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - debounced key level to SHORT/LONG/REPEAT/DOUBLE events; KEY_DBL_CLICK_EN enables double-click
module key_event_decoder #(
    parameter int CNT_W   = 11,
    parameter int LONG_MS = 1000,
    parameter int REP_MS  = 200,
    parameter int DBL_MS  = 300
) (
    input  logic                 clk_out,
    input  logic                 timer_rst,
    input  logic                 key_in,
    output logic                 key_busy,
    key_event_decoder_if.master  evt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRESS    = 3'd1;
    localparam logic [2:0] S_HELD     = 3'd2;
`ifdef KEY_DBL_CLICK_EN
    localparam logic [2:0] S_WAIT_DBL = 3'd3;
    localparam logic [2:0] S_PRESS2   = 3'd4;
`endif

    localparam logic [1:0] EVT_SHORT  = 2'b00;
    localparam logic [1:0] EVT_LONG   = 2'b01;
    localparam logic [1:0] EVT_REPEAT = 2'b10;
`ifdef KEY_DBL_CLICK_EN
    localparam logic [1:0] EVT_DOUBLE = 2'b11;
`endif

    // Terminal counts: the compare fires on the last cycle of each interval.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_MS - 1);
`ifdef KEY_DBL_CLICK_EN
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_MS - 1);
`endif

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             emit;
    logic [1:0]       emit_code;

    // Next-state, counter and event-request decode; cnt restarts on every state entry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        emit      = 1'b0;
        emit_code = EVT_SHORT;
        case (state)
            S_IDLE: begin
                if (key_in) begin
                    state_nxt = S_PRESS;
                end
            end
            S_PRESS: begin
                if (key_in) begin
                    if (cnt == LONG_LAST) begin
                        emit      = 1'b1;
                        emit_code = EVT_LONG;
                        state_nxt = S_HELD;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
`ifdef KEY_DBL_CLICK_EN
                    state_nxt = S_WAIT_DBL;
`else
                    emit      = 1'b1;
                    emit_code = EVT_SHORT;
                    state_nxt = S_IDLE;
`endif
                end
            end
            S_HELD: begin
                if (!key_in) begin
                    state_nxt = S_IDLE;
                end else if (cnt == REP_LAST) begin
                    emit      = 1'b1;
                    emit_code = EVT_REPEAT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef KEY_DBL_CLICK_EN
            S_WAIT_DBL: begin
                if (key_in) begin
                    emit      = 1'b1;
                    emit_code = EVT_DOUBLE;
                    state_nxt = S_PRESS2;
                end else if (cnt == DBL_LAST) begin
                    emit      = 1'b1;
                    emit_code = EVT_SHORT;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_PRESS2: begin
                if (!key_in) begin
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, counter and registered busy flag.
    always_ff @(posedge clk_out or posedge timer_rst) begin
        if (timer_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            key_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            key_busy <= (state_nxt != S_IDLE);
        end
    end

    // Single-entry event register: a same-edge accept frees the slot, otherwise a new event is dropped.
    always_ff @(posedge clk_out or posedge timer_rst) begin
        if (timer_rst) begin
            evt.evt_valid <= 1'b0;
            evt.evt_code  <= EVT_SHORT;
            evt.evt_ovf   <= 1'b0;
        end else if (emit) begin
            if (!evt.evt_valid || evt.evt_ready) begin
                evt.evt_valid <= 1'b1;
                evt.evt_code  <= emit_code;
            end else begin
                evt.evt_ovf   <= 1'b1;
            end
        end else if (evt.evt_valid && evt.evt_ready) begin
            evt.evt_valid <= 1'b0;
        end
    end

endmodule
